dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial DAC driver that consumes the 9-bit waveform samples from the trapezoid/triangle generator and ships each one to an external SPI DAC as a 16-bit frame. It sits directly downstream of the generator's `d_out` and drives the board DAC pins. A valid/ready handshake takes one sample per frame; samples presented while busy are dropped, so effective update rate is set by frame length.

## Interface
- `DIN_W`, 9: sample width; legal 1..12.
- `DIV`, 2: SCLK half-period in `clk` cycles; ≥1.
- `GAP`, 2: minimum `cs_n`-high cycles between frames; ≥1.
- `CMD`, 4'b0011: DAC command nibble placed in frame bits [15:12].

- `clk`  in  1  system clock; all logic on rising edge.
- `res`  in  1  asynchronous, active-high reset.
- `d_in`  in  DIN_W  sample from generator.
- `d_vld`  in  1  sample valid.
- `d_rdy`  out  1  block can accept a sample.
- `sclk`  out  1  SPI clock, idle low (mode 0).
- `cs_n`  out  1  DAC chip select, active low.
- `sdo`  out  1  serial data, MSB first.
- `done`  out  1  one-cycle pulse at end of each transmitted frame.

## Operation
- Reset values: `d_rdy`=1, `cs_n`=1, `sclk`=0, `sdo`=0, `done`=0, state IDLE, counters 0.
- Frame = {`CMD`, `d_in`, (12−DIN_W) zeros}. For DIN_W=9 this is {CMD, d_in[8:0], 3'b000}, with the sample left-aligned to 12-bit full scale.
- Accept: on an edge where `d_vld`=1 and `d_rdy`=1, capture the frame into a 16-bit shift register. `d_vld` is ignored while `d_rdy`=0; there is no queuing.
- States:
  - IDLE: `d_rdy`=1; goes to SHIFT on accept.
  - SHIFT: `cs_n`=0, `d_rdy`=0. Each bit is `DIV` cycles with `sclk` low, then `DIV` cycles with `sclk` high. `sdo` changes only while `sclk` is low, at the start of the bit. After 16 bits, go to HOLD.
  - HOLD: `cs_n`=1, `sclk`=0, `sdo`=0, `d_rdy`=0 for `GAP` cycles. `done`=1 in the first HOLD cycle only. Then return to IDLE.
- Counters: half-period counter 0..DIV−1; bit counter 0..15; gap counter 0..GAP−1. Every counter wraps back to 0 on state exit.
- Reset mid-frame: outputs return to their reset values immediately, asynchronously. The frame is abandoned and `done` does not pulse.
- `d_in` may change every cycle; only the value captured at accept is transmitted.

## Timing
- The accept edge is cycle 0.
- Cycles 1..32·DIV: `cs_n`=0. In cycle 1, `sdo`=frame[15] and `sclk`=0.
- Rising `sclk` edges of bit i (i=0..15, bit 15−i sent) fall at cycle 1+(2i+1)·DIV.
- Cycles 32·DIV+1 .. 32·DIV+GAP: HOLD. `done` is high in cycle 32·DIV+1.
- `d_rdy` returns to 1 in cycle 32·DIV+GAP+1. The earliest next accept is on that cycle.
- Defaults (DIV=2, GAP=2): `cs_n` low in cycles 1..64, `done` at 65, `d_rdy` high at 67. Period is 67 cycles per sample.

## Configuration
- Macro: `DAC_SKIP_SAME_EN`.
- Defined: a register holds the last transmitted 12-bit data field, plus a `have_last` flag cleared by reset.
  - An accepted sample whose field equals the stored value, with `have_last`=1, is consumed but sends no frame.
  - For such a sample: no `done` pulse, `cs_n` stays high, and `d_rdy` stays 1 on the next cycle.
  - The stored value and flag update only when a frame is actually sent.
- Undefined: every accepted sample is transmitted; the extra register and flag are absent.

## Test plan
- Defaults, accept `d_in`=9'h12B. Required: `sdo` over 16 `sclk` rises is 16'b0011_1001_0101_1000; `cs_n` low 64 cycles; `done` at cycle 65; `d_rdy` back at 67.
- `d_vld` held high, `d_in` incrementing every cycle. Required: only the values present at cycles 0, 67, 134 are transmitted, and no frame starts early.
- `res` asserted at cycle 30 of a frame. Required: `cs_n`=1, `sclk`=0, `d_rdy`=1 immediately, and no `done`. The next accept after release transmits correctly.
- DIV=1, GAP=1, `d_in`=9'h1FF. Required: frame 16'h3FF8, `cs_n` low 32 cycles, `done` at 33, `d_rdy` at 34.
- With `DAC_SKIP_SAME_EN`, send 9'h0 twice, then 9'h1. Required: the first 0 is transmitted (`have_last`=0); the second is consumed silently with `d_rdy` staying high; 9'h1 produces frame 16'h3008.
- Upstream integration with the trapezoid generator on a free-running `d_vld`=1. Required: the decoded DAC codes are monotonic on ramps and never exceed 299.

Source files
------------

// File: rtl/dac_spi_tx.sv
// SPI mode-0 DAC frame transmitter: {CMD, left-aligned sample} shifted MSB first.
// Optional DAC_SKIP_SAME_EN suppresses frames whose data field repeats the last one sent.
module dac_spi_tx #(
  parameter int          DIN_W = 9,
  parameter int          DIV   = 2,
  parameter int          GAP   = 2,
  parameter logic [3:0]  CMD   = 4'b0011
) (
  input  logic             clk,
  input  logic             res,
  input  logic [DIN_W-1:0] d_in,
  input  logic             d_vld,
  output logic             d_rdy,
  output logic             sclk,
  output logic             cs_n,
  output logic             sdo,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] hc_q, hc_d;
  logic        ph_q, ph_d;
  logic [3:0]  bc_q, bc_d;
  logic [15:0] gc_q, gc_d;
  logic [11:0] field;
  logic        send;

  // Sample left-aligned into the 12-bit DAC data field.
  assign field = 12'(d_in) << (12 - DIN_W);

`ifdef DAC_SKIP_SAME_EN
  logic [11:0] last_q, last_d;
  logic        have_q, have_d;

  assign send = !(have_q && (field == last_q));
`else
  assign send = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    hc_d    = hc_q;
    ph_d    = ph_q;
    bc_d    = bc_q;
    gc_d    = gc_q;
`ifdef DAC_SKIP_SAME_EN
    last_d  = last_q;
    have_d  = have_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_vld && send) begin
          state_d = SHIFT;
          sh_d    = {CMD, field};
`ifdef DAC_SKIP_SAME_EN
          last_d  = field;
          have_d  = 1'b1;
`endif
        end
      end
      SHIFT: begin
        if (hc_q == 16'(DIV - 1)) begin
          hc_d = '0;
          ph_d = ~ph_q;
          // End of the high half: advance to the next bit while sclk returns low.
          if (ph_q) begin
            sh_d = {sh_q[14:0], 1'b0};
            bc_d = bc_q + 4'd1;
            if (bc_q == 4'd15) begin
              state_d = HOLD;
              bc_d    = '0;
            end
          end
        end else begin
          hc_d = hc_q + 16'd1;
        end
      end
      HOLD: begin
        if (gc_q == 16'(GAP - 1)) begin
          gc_d    = '0;
          state_d = IDLE;
        end else begin
          gc_d = gc_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      sh_q    <= '0;
      hc_q    <= '0;
      ph_q    <= 1'b0;
      bc_q    <= '0;
      gc_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      hc_q    <= hc_d;
      ph_q    <= ph_d;
      bc_q    <= bc_d;
      gc_q    <= gc_d;
    end
  end

`ifdef DAC_SKIP_SAME_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      last_q <= '0;
      have_q <= 1'b0;
    end else begin
      last_q <= last_d;
      have_q <= have_d;
    end
  end
`endif

  // Outputs decode straight from state so reset forces them at once.
  assign d_rdy = (state_q == IDLE);
  assign cs_n  = (state_q != SHIFT);
  assign sclk  = (state_q == SHIFT) && ph_q;
  assign sdo   = (state_q == SHIFT) && sh_q[15];
  assign done  = (state_q == HOLD) && (gc_q == 16'd0);

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: default instance (DIV=2,GAP=2) and a DIV=1,GAP=1 instance,
// each checked every cycle against a timeline model derived from the frame timing.
module tb_dac_spi_tx;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [8:0] din [2];
  logic       vld [2];
  logic       rdy_w [2];
  logic       sclk_w [2];
  logic       cs_w [2];
  logic       sdo_w [2];
  logic       done_w [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_a [2] = '{2, 1};
  int gp_a [2] = '{2, 1};

  int          t0 [2] = '{0, 0};
  logic        act [2] = '{1'b0, 1'b0};
  logic [15:0] frm [2] = '{16'h0, 16'h0};
  logic        hl [2] = '{1'b0, 1'b0};
  logic [11:0] lst [2] = '{12'h0, 12'h0};

  dac_spi_tx u_dut0 (
    .clk(clk), .res(res), .d_in(din[0]), .d_vld(vld[0]), .d_rdy(rdy_w[0]),
    .sclk(sclk_w[0]), .cs_n(cs_w[0]), .sdo(sdo_w[0]), .done(done_w[0])
  );

  dac_spi_tx #(.DIN_W(9), .DIV(1), .GAP(1), .CMD(4'b0011)) u_dut1 (
    .clk(clk), .res(res), .d_in(din[1]), .d_vld(vld[1]), .d_rdy(rdy_w[1]),
    .sclk(sclk_w[1]), .cs_n(cs_w[1]), .sdo(sdo_w[1]), .done(done_w[1])
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Expected {d_rdy, cs_n, sclk, sdo, done} for cycle k after an accept edge.
  function automatic logic [4:0] model(int k, logic [15:0] f, int dv, int gp, logic a);
    int b;
    logic s;
    if (!a || k < 1 || k > 32 * dv + gp) return 5'b11000;
    if (k <= 32 * dv) begin
      b = (k - 1) / (2 * dv);
      s = ((k - 1) % (2 * dv)) >= dv;
      return {1'b0, 1'b0, s, f[15 - b], 1'b0};
    end
    return {1'b0, 1'b1, 1'b0, 1'b0, (k == 32 * dv + 1)};
  endfunction

  function automatic logic [4:0] exp_of(int i);
    return model(cyc - t0[i], frm[i], dv_a[i], gp_a[i], act[i]);
  endfunction

  function automatic logic m_rdy(int i);
    logic [4:0] e;
    e = exp_of(i);
    return e[4];
  endfunction

  function automatic logic m_start(int i);
    logic go;
    go = m_rdy(i) && vld[i];
`ifdef DAC_SKIP_SAME_EN
    if (hl[i] && ({din[i], 3'b000} == lst[i])) go = 1'b0;
`endif
    return go;
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 2; i++) begin
        act[i] <= 1'b0;
        hl[i]  <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_start(i)) begin
          act[i] <= 1'b1;
          t0[i]  <= cyc;
          frm[i] <= {4'b0011, din[i], 3'b000};
          hl[i]  <= 1'b1;
          lst[i] <= {din[i], 3'b000};
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rdy_w[i], cs_w[i], sclk_w[i], sdo_w[i], done_w[i]} != exp_of(i)) begin
        failures++;
        $display("FAIL cycle_dut%0d cyc=%0d got=%b exp=%b", i, cyc,
                 {rdy_w[i], cs_w[i], sclk_w[i], sdo_w[i], done_w[i]}, exp_of(i));
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Send one sample and measure the frame from the pins, cycle 1 onward.
  task automatic send_meas(input int i, input logic [8:0] v, output int cs_cnt,
                           output int done_k, output int rdy_k, output logic [15:0] bits);
    logic ps;
    cs_cnt = 0; done_k = -1; rdy_k = -1; bits = '0; ps = 1'b0;
    @(negedge clk); #1;
    din[i] = v; vld[i] = 1'b1;
    @(negedge clk); #1;
    vld[i] = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (!cs_w[i]) cs_cnt++;
      if (done_w[i]) done_k = k;
      if (sclk_w[i] && !ps) bits = {bits[14:0], sdo_w[i]};
      ps = sclk_w[i];
      if (rdy_w[i]) begin
        rdy_k = k;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (!rdy_w[i] && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_reached", int'(rdy_w[i]), 1);
  endtask

  int          cs_cnt, done_k, rdy_k, dcount;
  logic [15:0] bits;
  logic [15:0] fq [$];
  logic [8:0]  v0;
  logic        ps;

  initial begin
    din[0] = '0; din[1] = '0; vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", int'(rdy_w[0]), 1);
    chk("rst_cs_n", int'(cs_w[0]), 1);
    chk("rst_sclk", int'(sclk_w[0]), 0);
    chk("rst_sdo", int'(sdo_w[0]), 0);
    chk("rst_done", int'(done_w[0]), 0);
    #1 res = 1'b0;

    send_meas(0, 9'h12B, cs_cnt, done_k, rdy_k, bits);
    chk("f12b_bits", int'(bits), 16'h3958);
    chk("f12b_cslow", cs_cnt, 64);
    chk("f12b_done", done_k, 65);
    chk("f12b_rdy", rdy_k, 67);

    send_meas(1, 9'h1FF, cs_cnt, done_k, rdy_k, bits);
    chk("div1_bits", int'(bits), 16'h3FF8);
    chk("div1_cslow", cs_cnt, 32);
    chk("div1_done", done_k, 33);
    chk("div1_rdy", rdy_k, 34);

    // Free-running valid with a sample that changes every cycle.
    v0 = 9'h050;
    @(negedge clk); #1;
    din[0] = v0; vld[0] = 1'b1; ps = 1'b0; bits = '0;
    for (int n = 0; n < 400 && fq.size() < 3; n++) begin
      @(negedge clk); #1;
      if (sclk_w[0] && !ps) bits = {bits[14:0], sdo_w[0]};
      ps = sclk_w[0];
      if (done_w[0]) fq.push_back(bits);
      din[0] = din[0] + 9'd1;
    end
    vld[0] = 1'b0;
    chk("inc_frames", fq.size(), 3);
    for (int j = 0; j < 3 && j < fq.size(); j++)
      chk("inc_frame_val", int'(fq[j]), int'({4'b0011, 9'(v0 + 9'(67 * j)), 3'b000}));
    wait_idle(0);

    // Reset 30 cycles into a frame.
    @(negedge clk); #1;
    din[0] = 9'h0AA; vld[0] = 1'b1;
    @(negedge clk); #1;
    vld[0] = 1'b0;
    repeat (29) @(negedge clk);
    #2 res = 1'b1;
    #1;
    chk("midrst_cs_n", int'(cs_w[0]), 1);
    chk("midrst_sclk", int'(sclk_w[0]), 0);
    chk("midrst_rdy", int'(rdy_w[0]), 1);
    dcount = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      if (done_w[0]) dcount++;
    end
    #1 res = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (done_w[0]) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    send_meas(0, 9'h155, cs_cnt, done_k, rdy_k, bits);
    chk("postrst_bits", int'(bits), 16'h3AA8);
    chk("postrst_done", done_k, 65);

`ifdef DAC_SKIP_SAME_EN
    @(negedge clk); #2 res = 1'b1;
    @(negedge clk); #2 res = 1'b0;
    send_meas(0, 9'h000, cs_cnt, done_k, rdy_k, bits);
    chk("skip_first_bits", int'(bits), 16'h3000);
    chk("skip_first_rdy", rdy_k, 67);
    @(negedge clk); #1;
    din[0] = 9'h000; vld[0] = 1'b1;
    @(negedge clk); #1;
    vld[0] = 1'b0;
    chk("skip_rdy_held", int'(rdy_w[0]), 1);
    cs_cnt = 0; dcount = 0;
    for (int n = 0; n < 6; n++) begin
      if (!cs_w[0]) cs_cnt++;
      if (done_w[0]) dcount++;
      @(negedge clk); #1;
    end
    chk("skip_no_cs", cs_cnt, 0);
    chk("skip_no_done", dcount, 0);
    send_meas(0, 9'h001, cs_cnt, done_k, rdy_k, bits);
    chk("skip_next_bits", int'(bits), 16'h3008);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
